// File: rtl/jedro_1_boot_loader.sv
// jedro_1_boot_loader: byte-serial program loader that fills instruction RAM and then releases the core reset
module jedro_1_boot_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               s_valid_i,
    input  logic [7:0]                         s_data_i,
    input  logic                               s_last_i,
    output logic                               s_ready_o,
    output logic                               mem_we_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    output logic                               core_rstn_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [$clog2(MAX_WORDS+1)-1:0]     word_cnt_o
);
    localparam int            CW   = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_core_rstn;
    logic                  r_done;
    logic                  r_err;

    state_t                w_state_nxt;
    logic [1:0]            w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_word_nxt;
    logic                  w_last_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_ready_nxt;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  w_err_nxt;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_asm;

    assign w_accept = s_valid_i & r_ready;
    assign w_asm    = r_word | (DATA_WIDTH'(s_data_i) << {r_idx, 3'b000});

    // Next-state and next-output logic; outputs are precomputed from the next state so they can be registered
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: w_state_nxt = S_RECV;
            S_RECV: begin
                if (w_accept) begin
                    if (r_idx == 2'd3 || s_last_i) begin
                        w_last_nxt = s_last_i;
                        if (r_cnt == MAXW) begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_WRITE;
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = BASE_ADDR + (ADDR_WIDTH'(r_cnt) << 2);
                            w_wdata_nxt = w_asm;
                        end
                    end else begin
                        w_word_nxt = w_asm;
                        w_idx_nxt  = r_idx + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                w_cnt_nxt   = r_cnt + CW'(1);
                w_idx_nxt   = 2'd0;
                w_word_nxt  = '0;
                w_state_nxt = r_last ? S_DONE : S_RECV;
            end
            S_ERROR: w_last_nxt = r_last | (w_accept & s_last_i);
            default: w_state_nxt = r_state;
        endcase
        w_ready_nxt = (w_state_nxt == S_RECV) | ((w_state_nxt == S_ERROR) & ~w_last_nxt);
    end

    // State and registered outputs; reset clears everything at once, dropping any in-flight write
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_core_rstn <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_word      <= w_word_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= w_ready_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_core_rstn <= (w_state_nxt == S_DONE);
            r_done      <= (w_state_nxt == S_DONE);
            r_err       <= w_err_nxt;
        end
    end

    assign s_ready_o   = r_ready;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign core_rstn_o = r_core_rstn;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign word_cnt_o  = r_cnt;
endmodule

// File: tb/tb_jedro_1_boot_loader.sv
// tb_jedro_1_boot_loader: directed checks of the boot loader (default, overflow and relocated instances)
module tb_jedro_1_boot_loader;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;

    logic        m_ready, m_we, m_core, m_done, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [10:0] m_cnt;
    logic        o_ready, o_we, o_core, o_done, o_err;
    logic [31:0] o_addr, o_wdata;
    logic [1:0]  o_cnt;
    logic        b_ready, b_we, b_core, b_done, b_err;
    logic [31:0] b_addr, b_wdata;
    logic [10:0] b_cnt;

    int n_chk = 0;
    int n_err = 0;
    int n_viol = 0;
    int n_acc = 0;
    logic [63:0] q_m[$];
    logic [63:0] q_o[$];
    logic [63:0] q_b[$];

    always #5 clk = ~clk;

    jedro_1_boot_loader u_main (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(m_ready), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
        .core_rstn_o(m_core), .done_o(m_done), .err_o(m_err), .word_cnt_o(m_cnt)
    );

    jedro_1_boot_loader #(.MAX_WORDS(2)) u_ovf (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(o_ready), .mem_we_o(o_we), .mem_addr_o(o_addr), .mem_wdata_o(o_wdata),
        .core_rstn_o(o_core), .done_o(o_done), .err_o(o_err), .word_cnt_o(o_cnt)
    );

    jedro_1_boot_loader #(.BASE_ADDR(32'h100)) u_base (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(b_ready), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
        .core_rstn_o(b_core), .done_o(b_done), .err_o(b_err), .word_cnt_o(b_cnt)
    );

    // Write logs and stream accounting, sampled on the active edge before the DUT updates
    always @(posedge clk) begin
        if (m_we) q_m.push_back({m_addr, m_wdata});
        if (o_we) q_o.push_back({o_addr, o_wdata});
        if (b_we) q_b.push_back({b_addr, b_wdata});
        if (m_we && m_ready) n_viol++;
        if (s_valid && m_ready) n_acc++;
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [10:0] cnt;
        logic        done;
        logic        core;
    } vec_t;

    vec_t tv[18];
    logic [7:0] img[12];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] m_outs();
        return {m_ready, m_we, m_addr, m_wdata, m_cnt, m_done, m_core, m_err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        s_valid = 1'b0;
        s_last = 1'b0;
        rstn = 1'b0;
        #1;
        chk(nm, m_outs(), 96'h0);
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (!m_ready && n < 100) begin
            cyc();
            n++;
        end
        if (!m_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: ready=%0b required 1", m_ready);
        end else begin
            s_valid = 1'b1;
            s_data = d;
            s_last = l;
            cyc();
            s_valid = 1'b0;
            s_last = 1'b0;
        end
    endtask

    task automatic send_image(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    s_data = 8'($urandom);
                    s_last = 1'($urandom);
                    cyc();
                end
                s_last = 1'b0;
            end
            send(img[i], i == nbytes - 1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!m_done && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_done", 96'(m_done), 96'h1);
    endtask

    initial begin
        int qm, qo, qb, acc0;
        img = '{8'hB7, 8'h10, 8'h00, 8'h00, 8'h37, 8'h21, 8'h00, 8'h00, 8'hB7, 8'h31, 8'h00, 8'h00};
        tv[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 8'hB7, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        11'd0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, 32'h000010B7, 11'd0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000010B7, 11'd1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 8'h37, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000010B7, 11'd1, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0, 32'h000010B7, 11'd1, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000010B7, 11'd1, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000010B7, 11'd1, 1'b0, 1'b0};
        tv[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 32'h4, 32'h00002137, 11'd1, 1'b0, 1'b0};
        tv[11] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 32'h4, 32'h00002137, 11'd2, 1'b0, 1'b0};
        tv[12] = '{1'b1, 8'hB7, 1'b0, 1'b1, 1'b0, 32'h4, 32'h00002137, 11'd2, 1'b0, 1'b0};
        tv[13] = '{1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 32'h4, 32'h00002137, 11'd2, 1'b0, 1'b0};
        tv[14] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h4, 32'h00002137, 11'd2, 1'b0, 1'b0};
        tv[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 32'h8, 32'h000031B7, 11'd2, 1'b0, 1'b0};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h8, 32'h000031B7, 11'd3, 1'b1, 1'b1};
        tv[17] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 32'h8, 32'h000031B7, 11'd3, 1'b1, 1'b1};

        #1;
        do_reset("reset_state");
        qm = q_m.size();
        qo = q_o.size();
        qb = q_b.size();
        for (int i = 0; i < 18; i++) begin
            s_valid = tv[i].v;
            s_data = tv[i].d;
            s_last = tv[i].l;
            cyc();
            chk($sformatf("vec%0d", i), m_outs(),
                {tv[i].rdy, tv[i].we, tv[i].addr, tv[i].wd, tv[i].cnt, tv[i].done, tv[i].core, 1'b0});
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("normal_writes", 96'(q_m.size() - qm), 96'd3);
        chk("ovf_flags", {o_err, o_done, o_core, o_ready, o_cnt}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd2});
        chk("ovf_writes", 96'(q_o.size() - qo), 96'd2);
        chk("ovf_w1", 96'(q_o[qo + 1]), {32'h0, 32'h4, 32'h00002137});
        chk("base_writes", 96'(q_b.size() - qb), 96'd3);
        chk("base_w0", 96'(q_b[qb]), {32'h0, 32'h100, 32'h000010B7});
        chk("base_w1", 96'(q_b[qb + 1]), {32'h0, 32'h104, 32'h00002137});

        do_reset("reset_partial");
        qm = q_m.size();
        send_image(6, 1'b0);
        wait_done();
        chk("partial_writes", 96'(q_m.size() - qm), 96'd2);
        chk("partial_w1", 96'(q_m[qm + 1]), {32'h0, 32'h4, 32'h00002137});
        chk("partial_cnt", 96'(m_cnt), 96'd2);

        do_reset("reset_gap");
        qm = q_m.size();
        acc0 = n_acc;
        send_image(12, 1'b1);
        wait_done();
        chk("gap_w0", 96'(q_m[qm]), {32'h0, 32'h0, 32'h000010B7});
        chk("gap_w1", 96'(q_m[qm + 1]), {32'h0, 32'h4, 32'h00002137});
        chk("gap_w2", 96'(q_m[qm + 2]), {32'h0, 32'h8, 32'h000031B7});
        chk("gap_pulses", 96'(q_m.size() - qm), 96'((n_acc - acc0) / 4));
        chk("ready_in_write", 96'(n_viol), 96'd0);

        do_reset("reset_inflight");
        for (int i = 0; i < 4; i++) send(img[i], 1'b0);
        chk("we_before_reset", 96'(m_we), 96'h1);
        rstn = 1'b0;
        #1;
        chk("we_async_clear", m_outs(), 96'h0);
        cyc();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) send(img[i], 1'b0);
        chk("cnt_before_reset", 96'(m_cnt), 96'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midword_clear", m_outs(), 96'h0);
        cyc();
        rstn = 1'b1;
        qm = q_m.size();
        send_image(12, 1'b0);
        wait_done();
        chk("reload_w0", 96'(q_m[qm]), {32'h0, 32'h0, 32'h000010B7});
        chk("reload_done", {m_done, m_core, m_cnt}, {1'b1, 1'b1, 11'd3});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
